// File: rtl/sprite_frame_ctrl.sv
// sprite_frame_ctrl: raster timing generator and per-frame parameter owner
// for the sprite renderer. Counters, sync strobes and blanking are produced
// in the pixel clock domain. Game-logic updates arrive through a valid/ready
// handshake and are committed only at the start of vertical blanking, so a
// frame is never drawn with a mix of old and new parameters.
module sprite_frame_ctrl #(
  parameter int          H_ACTIVE = 1280,
  parameter int          H_FP     = 110,
  parameter int          H_SYNC   = 40,
  parameter int          H_BP     = 220,
  parameter int          V_ACTIVE = 720,
  parameter int          V_FP     = 5,
  parameter int          V_SYNC   = 5,
  parameter int          V_BP     = 20,
  parameter int          ANGLE_W  = 1,
  parameter logic [15:0] INIT_X   = 16'h4000,
  parameter logic [15:0] INIT_Y   = 16'h0A00
) (
  input  logic               pixel_clk_in,
  input  logic               rst_in,
  input  logic               upd_valid_in,
  input  logic [15:0]        upd_ballx_in,
  input  logic [15:0]        upd_bally_in,
  input  logic [ANGLE_W-1:0] upd_angle_in,
  output logic               upd_ready_out,
  output logic [10:0]        hcount_out,
  output logic [9:0]         vcount_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               active_draw_out,
  output logic               new_frame_out,
  output logic [5:0]         frame_count_out,
  output logic [15:0]        ballx_out,
  output logic [15:0]        bally_out,
  output logic [ANGLE_W-1:0] angle_out,
  output logic               commit_out
);

  // Raster geometry derived from the porch/sync/active widths.
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VISIBLE   = 11'(H_ACTIVE);
  localparam logic [9:0]  V_VISIBLE   = 10'(V_ACTIVE);
  localparam logic [10:0] HS_START    = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END      = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  VS_START    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END      = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0]  COMMIT_LINE = 10'(V_ACTIVE - 1);

  // Update handshake states: EMPTY accepts, PENDING holds until commit.
  typedef enum logic {
    EMPTY   = 1'b0,
    PENDING = 1'b1
  } upd_state_t;

  upd_state_t         state;
  upd_state_t         state_next;

  logic [10:0]        h_next;
  logic [9:0]         v_next;
  logic               frame_start_next;
  logic               commit_edge;
  logic               accept;
  logic               do_commit;

  logic [15:0]        pend_ballx;
  logic [15:0]        pend_bally;
  logic [ANGLE_W-1:0] pend_angle;

  // Next raster position: hcount wraps each line, vcount steps on that wrap.
  always_comb begin
    h_next = hcount_out + 11'd1;
    v_next = vcount_out;
    if (hcount_out == H_LAST) begin
      h_next = '0;
      if (vcount_out == V_LAST) begin
        v_next = '0;
      end else begin
        v_next = vcount_out + 10'd1;
      end
    end
  end

  assign frame_start_next = (h_next == '0) && (v_next == '0);

  // The commit edge is the one leaving the last pixel of the last visible
  // line, so new parameters show up on the first blanking line.
  assign commit_edge = (hcount_out == H_LAST) && (vcount_out == COMMIT_LINE);

  assign accept        = (state == EMPTY) && upd_valid_in;
  assign do_commit     = (state == PENDING) && commit_edge;
  assign upd_ready_out = (state == EMPTY);

  // Counters plus decodes computed from the next position, so every decoded
  // strobe lines up with the counter value shown in the same cycle.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hcount_out      <= '0;
      vcount_out      <= '0;
      hsync_out       <= 1'b0;
      vsync_out       <= 1'b0;
      active_draw_out <= 1'b1;
      new_frame_out   <= 1'b1;
    end else begin
      hcount_out      <= h_next;
      vcount_out      <= v_next;
      hsync_out       <= (h_next >= HS_START) && (h_next <= HS_END);
      vsync_out       <= (v_next >= VS_START) && (v_next <= VS_END);
      active_draw_out <= (h_next < H_VISIBLE) && (v_next < V_VISIBLE);
      new_frame_out   <= frame_start_next;
    end
  end

  // Frame counter advances on the edge into (0,0) and wraps naturally.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      frame_count_out <= '0;
    end else if (frame_start_next) begin
      frame_count_out <= frame_count_out + 6'd1;
    end
  end

  // Update FSM state register.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; an accept on the commit edge only reaches PENDING and
  // waits a full frame, since commit requires PENDING beforehand.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: begin
        if (upd_valid_in) begin
          state_next = PENDING;
        end
      end
      PENDING: begin
        if (commit_edge) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Pending holding register, loaded only while the FSM accepts.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pend_ballx <= '0;
      pend_bally <= '0;
      pend_angle <= '0;
    end else if (accept) begin
      pend_ballx <= upd_ballx_in;
      pend_bally <= upd_bally_in;
      pend_angle <= upd_angle_in;
    end
  end

  // Committed parameters seen by the renderer, plus the one-cycle pulse.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ballx_out  <= INIT_X;
      bally_out  <= INIT_Y;
      angle_out  <= '0;
      commit_out <= 1'b0;
    end else begin
      commit_out <= do_commit;
      if (do_commit) begin
        ballx_out <= pend_ballx;
        bally_out <= pend_bally;
        angle_out <= pend_angle;
      end
    end
  end

endmodule

// File: tb/tb_sprite_frame_ctrl.sv
// Testbench for sprite_frame_ctrl using a shrunken raster so whole frames
// stay short. Raster behaviour is checked against an independent counter
// model; committed updates go through an expected-value queue.
module tb_sprite_frame_ctrl;

  localparam int H_ACTIVE = 16;
  localparam int H_FP     = 4;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 5;
  localparam int V_ACTIVE = 10;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 3;
  localparam int ANGLE_W  = 1;
  localparam int H_TOTAL  = 28;
  localparam int V_TOTAL  = 17;
  localparam int FRAME    = 476;
  localparam logic [15:0] INIT_X = 16'h4000;
  localparam logic [15:0] INIT_Y = 16'h0A00;

  typedef struct packed {
    logic [15:0]        x;
    logic [15:0]        y;
    logic [ANGLE_W-1:0] a;
  } upd_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               upd_valid;
  logic [15:0]        upd_x;
  logic [15:0]        upd_y;
  logic [ANGLE_W-1:0] upd_a;
  logic               upd_ready;
  logic [10:0]        hcount;
  logic [9:0]         vcount;
  logic               hsync;
  logic               vsync;
  logic               active;
  logic               new_frame;
  logic [5:0]         frame_count;
  logic [15:0]        ballx;
  logic [15:0]        bally;
  logic [ANGLE_W-1:0] angle;
  logic               commit;

  int   checks = 0;
  int   errors = 0;
  int   m_h = 0;
  int   m_v = 0;
  upd_t cur;
  upd_t exp_q[$];

  sprite_frame_ctrl #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .ANGLE_W(ANGLE_W), .INIT_X(INIT_X), .INIT_Y(INIT_Y)
  ) dut (
    .pixel_clk_in   (clk),
    .rst_in         (rst_n),
    .upd_valid_in   (upd_valid),
    .upd_ballx_in   (upd_x),
    .upd_bally_in   (upd_y),
    .upd_angle_in   (upd_a),
    .upd_ready_out  (upd_ready),
    .hcount_out     (hcount),
    .vcount_out     (vcount),
    .hsync_out      (hsync),
    .vsync_out      (vsync),
    .active_draw_out(active),
    .new_frame_out  (new_frame),
    .frame_count_out(frame_count),
    .ballx_out      (ballx),
    .bally_out      (bally),
    .angle_out      (angle),
    .commit_out     (commit)
  );

  always #5 clk = ~clk;

  // Advance one clock and the raster model, then sample 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_h = 0;
      m_v = 0;
    end else if (m_h == H_TOTAL - 1) begin
      m_h = 0;
      m_v = (m_v == V_TOTAL - 1) ? 0 : m_v + 1;
    end else begin
      m_h = m_h + 1;
    end
    #1;
  endtask

  // Move the model to a target position (always reachable within two frames).
  task automatic run_to(input int h, input int v);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (m_h == h && m_v == v) break;
      tick();
    end
  endtask

  // Reset for three cycles, release on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    upd_valid = 1'b0;
    m_h = 0;
    m_v = 0;
    cur = '{x: INIT_X, y: INIT_Y, a: '0};
    exp_q.delete();
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [62:0] got;
    logic [62:0] exp;
    rst_n = 1'b0;
    upd_valid = 1'b0;
    m_h = 0;
    m_v = 0;
    cur = '{x: INIT_X, y: INIT_Y, a: '0};
    repeat (3) tick();
    got = {hcount, vcount, hsync, vsync, active, new_frame, frame_count, commit, upd_ready, ballx, bally, angle};
    exp = {11'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 1'b0, 1'b1, INIT_X, INIT_Y, 1'b0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", got, exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if ({hcount, vcount, new_frame} !== {11'd1, 10'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL first_edge: got h=%0d v=%0d nf=%b expected h=1 v=0 nf=0", hcount, vcount, new_frame);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    run_to(H_TOTAL - 1, 0);
    tick();
    checks++;
    if ({hcount, vcount} !== {11'd0, 10'd1}) begin
      errors++;
      $display("[TB] FAIL line_wrap: got h=%0d v=%0d expected h=0 v=1", hcount, vcount);
    end
    run_to(H_TOTAL - 1, V_TOTAL - 1);
    checks++;
    if ({hcount, vcount, frame_count, new_frame} !== {11'd27, 10'd16, 6'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL frame_end: got h=%0d v=%0d fc=%0d nf=%b expected h=27 v=16 fc=0 nf=0",
               hcount, vcount, frame_count, new_frame);
    end
    tick();
    checks++;
    if ({hcount, vcount, frame_count, new_frame} !== {11'd0, 10'd0, 6'd1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL frame_wrap: got h=%0d v=%0d fc=%0d nf=%b expected h=0 v=0 fc=1 nf=1",
               hcount, vcount, frame_count, new_frame);
    end
    tick();
    checks++;
    if (new_frame !== 1'b0) begin
      errors++;
      $display("[TB] FAIL new_frame_pulse: got %b expected 0", new_frame);
    end
  endtask

  task automatic test_sync_windows();
    int bad_cnt = 0;
    int bad_dec = 0;
    int hs_cnt = 0;
    int vs_cnt = 0;
    int act_cnt = 0;
    logic eh, ev, ea, en;
    run_to(0, 0);
    for (int i = 0; i < FRAME; i++) begin
      eh = (m_h >= H_ACTIVE + H_FP) && (m_h < H_ACTIVE + H_FP + H_SYNC);
      ev = (m_v >= V_ACTIVE + V_FP) && (m_v < V_ACTIVE + V_FP + V_SYNC);
      ea = (m_h < H_ACTIVE) && (m_v < V_ACTIVE);
      en = (m_h == 0) && (m_v == 0);
      if ({hcount, vcount} !== {11'(m_h), 10'(m_v)}) bad_cnt++;
      if ({hsync, vsync, active, new_frame} !== {eh, ev, ea, en}) bad_dec++;
      if (hsync === 1'b1) hs_cnt++;
      if (vsync === 1'b1) vs_cnt++;
      if (active === 1'b1) act_cnt++;
      tick();
    end
    checks++;
    if (bad_cnt != 0) begin
      errors++;
      $display("[TB] FAIL counter_track: got %0d bad cycles expected 0", bad_cnt);
    end
    checks++;
    if (bad_dec != 0) begin
      errors++;
      $display("[TB] FAIL decode_windows: got %0d bad cycles expected 0", bad_dec);
    end
    checks++;
    if (hs_cnt != H_SYNC * V_TOTAL) begin
      errors++;
      $display("[TB] FAIL hsync_count: got %0d expected %0d", hs_cnt, H_SYNC * V_TOTAL);
    end
    checks++;
    if (vs_cnt != V_SYNC * H_TOTAL) begin
      errors++;
      $display("[TB] FAIL vsync_count: got %0d expected %0d", vs_cnt, V_SYNC * H_TOTAL);
    end
    checks++;
    if (act_cnt != 160) begin
      errors++;
      $display("[TB] FAIL active_count: got %0d expected 160", act_cnt);
    end
  endtask

  task automatic test_frame_count_wrap();
    do_reset();
    repeat (63 * FRAME) tick();
    checks++;
    if ({hcount, vcount, frame_count} !== {11'd0, 10'd0, 6'd63}) begin
      errors++;
      $display("[TB] FAIL frame_count_63: got h=%0d v=%0d fc=%0d expected h=0 v=0 fc=63", hcount, vcount, frame_count);
    end
    repeat (FRAME) tick();
    checks++;
    if ({frame_count, new_frame} !== {6'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL frame_count_wrap: got fc=%0d nf=%b expected fc=0 nf=1", frame_count, new_frame);
    end
  endtask

  task automatic test_commit();
    int   n = 0;
    int   bad = 0;
    upd_t e;
    do_reset();
    run_to(8, 3);
    checks++;
    if (upd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL commit_ready_before: got %b expected 1", upd_ready);
    end
    upd_valid = 1'b1;
    upd_x = 16'h5000;
    upd_y = 16'h2000;
    upd_a = 1'b1;
    exp_q.push_back('{x: 16'h5000, y: 16'h2000, a: 1'b1});
    tick();
    upd_valid = 1'b0;
    checks++;
    if (upd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL commit_ready_fall: got %b expected 0", upd_ready);
    end
    while (commit !== 1'b1 && n < FRAME + 2) begin
      if ({ballx, bally, angle} !== cur) bad++;
      tick();
      n++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL commit_hold: got %0d early changes expected 0", bad);
    end
    checks++;
    if ({commit, hcount, vcount} !== {1'b1, 11'd0, 10'(V_ACTIVE)}) begin
      errors++;
      $display("[TB] FAIL commit_position: got c=%b h=%0d v=%0d expected c=1 h=0 v=%0d", commit, hcount, vcount, V_ACTIVE);
    end
    e = exp_q.pop_front();
    cur = e;
    checks++;
    if ({ballx, bally, angle} !== e) begin
      errors++;
      $display("[TB] FAIL commit_values: got %h expected %h", {ballx, bally, angle}, e);
    end
    tick();
    checks++;
    if ({commit, upd_ready, ballx, bally, angle} !== {1'b0, 1'b1, cur}) begin
      errors++;
      $display("[TB] FAIL commit_after: got c=%b r=%b v=%h expected c=0 r=1 v=%h", commit, upd_ready, {ballx, bally, angle}, cur);
    end
  endtask

  task automatic test_collision();
    int   n = 0;
    int   bad = 0;
    upd_t e;
    run_to(H_TOTAL - 1, V_ACTIVE - 1);
    checks++;
    if (upd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL collision_ready: got %b expected 1", upd_ready);
    end
    upd_valid = 1'b1;
    upd_x = 16'h1234;
    upd_y = 16'h5678;
    upd_a = 1'b0;
    exp_q.push_back('{x: 16'h1234, y: 16'h5678, a: 1'b0});
    tick();
    upd_valid = 1'b0;
    checks++;
    if ({commit, upd_ready, ballx, bally, angle} !== {1'b0, 1'b0, cur}) begin
      errors++;
      $display("[TB] FAIL collision_no_commit: got c=%b r=%b v=%h expected c=0 r=0 v=%h", commit, upd_ready, {ballx, bally, angle}, cur);
    end
    tick();
    n = 1;
    while (commit !== 1'b1 && n < FRAME + 5) begin
      if ({ballx, bally, angle} !== cur) bad++;
      tick();
      n++;
    end
    checks++;
    if (n != FRAME || bad != 0) begin
      errors++;
      $display("[TB] FAIL collision_delay: got %0d cycles %0d changes expected %0d cycles 0 changes", n, bad, FRAME);
    end
    e = exp_q.pop_front();
    cur = e;
    checks++;
    if ({ballx, bally, angle} !== e) begin
      errors++;
      $display("[TB] FAIL collision_values: got %h expected %h", {ballx, bally, angle}, e);
    end
  endtask

  task automatic test_back_to_back();
    int   n = 0;
    upd_t e;
    run_to(3, 2);
    upd_valid = 1'b1;
    upd_x = 16'h1111;
    upd_y = 16'h2222;
    upd_a = 1'b1;
    exp_q.push_back('{x: 16'h1111, y: 16'h2222, a: 1'b1});
    tick();
    upd_x = 16'h3333;
    upd_y = 16'h4444;
    upd_a = 1'b0;
    while (commit !== 1'b1 && n < FRAME + 2) begin
      tick();
      n++;
    end
    e = exp_q.pop_front();
    cur = e;
    checks++;
    if ({commit, ballx, bally, angle} !== {1'b1, e}) begin
      errors++;
      $display("[TB] FAIL b2b_first: got c=%b v=%h expected c=1 v=%h", commit, {ballx, bally, angle}, e);
    end
    checks++;
    if (upd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_ready_rise: got %b expected 1", upd_ready);
    end
    exp_q.push_back('{x: 16'h3333, y: 16'h4444, a: 1'b0});
    tick();
    upd_valid = 1'b0;
    n = 1;
    while (commit !== 1'b1 && n < FRAME + 5) begin
      tick();
      n++;
    end
    e = exp_q.pop_front();
    cur = e;
    checks++;
    if ({commit, ballx, bally, angle} !== {1'b1, e} || n != FRAME) begin
      errors++;
      $display("[TB] FAIL b2b_second: got c=%b v=%h after %0d expected c=1 v=%h after %0d",
               commit, {ballx, bally, angle}, n, e, FRAME);
    end
  endtask

  task automatic test_async_reset();
    int          seen = 0;
    logic [62:0] got;
    logic [62:0] exp;
    run_to(5, 1);
    upd_valid = 1'b1;
    upd_x = 16'hBEEF;
    upd_y = 16'hCAFE;
    upd_a = 1'b1;
    exp_q.push_back('{x: 16'hBEEF, y: 16'hCAFE, a: 1'b1});
    tick();
    upd_valid = 1'b0;
    run_to(12, 5);
    checks++;
    if (upd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_pending: got ready=%b expected 0", upd_ready);
    end
    #3;
    rst_n = 1'b0;
    m_h = 0;
    m_v = 0;
    cur = '{x: INIT_X, y: INIT_Y, a: '0};
    exp_q.delete();
    #1;
    got = {hcount, vcount, hsync, vsync, active, new_frame, frame_count, commit, upd_ready, ballx, bally, angle};
    exp = {11'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 1'b0, 1'b1, INIT_X, INIT_Y, 1'b0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL async_reset_outputs: got %h expected %h", got, exp);
    end
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (commit === 1'b1 || {ballx, bally, angle} !== cur) seen++;
    end
    checks++;
    if (seen != 0 || upd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_discard: got %0d commit/changes ready=%b expected 0 ready=1", seen, upd_ready);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    upd_valid = 1'b0;
    upd_x = '0;
    upd_y = '0;
    upd_a = '0;
    test_reset();
    test_wrap();
    test_sync_windows();
    test_frame_count_wrap();
    test_commit();
    test_collision();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got no completion expected finish before 2000000ns");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/sprite_frame_ctrl.md
# sprite_frame_ctrl

Frame-level controller for the sprite renderer (map_sprite_3 and successors). It generates the 1280x720 raster counters and sync strobes that drive the renderer's `hcount_in`/`vcount_in`. It also owns the renderer's per-frame parameters (ball position, angle), accepting updates from game logic through a valid/ready handshake. Updates are committed only at the start of vertical blanking, so a frame is never drawn with mixed parameters. Sits between game logic and the sprite/video output path, in the pixel clock domain.

## Interface
- `H_ACTIVE`, 1280, visible pixels per line
- `H_FP`, 110, horizontal front porch (cycles)
- `H_SYNC`, 40, hsync width (cycles)
- `H_BP`, 220, horizontal back porch (cycles)
- `V_ACTIVE`, 720, visible lines
- `V_FP`, 5, vertical front porch (lines)
- `V_SYNC`, 5, vsync width (lines)
- `V_BP`, 20, vertical back porch (lines)
- `ANGLE_W`, 1, angle field width
- `INIT_X`, 16'h4000, reset value of committed ballx (8.8 fixed point)
- `INIT_Y`, 16'h0A00, reset value of committed bally (8.8 fixed point)

Ports:
- `pixel_clk_in`  in  1  pixel clock; all logic on rising edge
- `rst_in`  in  1  asynchronous, active-low reset
- `upd_valid_in`  in  1  game logic presents a parameter update
- `upd_ballx_in`  in  16  new ballx, 8.8 fixed point
- `upd_bally_in`  in  16  new bally, 8.8 fixed point
- `upd_angle_in`  in  ANGLE_W  new angle
- `upd_ready_out`  out  1  controller can accept an update
- `hcount_out`  out  11  horizontal position, 0..H_TOTAL-1
- `vcount_out`  out  10  vertical position, 0..V_TOTAL-1
- `hsync_out`  out  1  horizontal sync, active-high
- `vsync_out`  out  1  vertical sync, active-high
- `active_draw_out`  out  1  current position is visible
- `new_frame_out`  out  1  one-cycle pulse at (0,0)
- `frame_count_out`  out  6  frame counter, wraps
- `ballx_out`, `bally_out`  out  16  committed parameters to renderer
- `angle_out`  out  ANGLE_W  committed angle
- `commit_out`  out  1  one-cycle pulse when new parameters take effect

## Operation
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1650.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 750.
- Raster counters:
  - `hcount_out` increments every cycle and wraps H_TOTAL-1 → 0.
  - `vcount_out` increments on each hcount wrap and wraps V_TOTAL-1 → 0.
- Decoded outputs are registered and aligned with the counter values shown in the same cycle:
  - `hsync_out` = hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 1390..1429.
  - `vsync_out` = vcount in [725, 729].
  - `active_draw_out` = hcount<1280 && vcount<720.
  - `new_frame_out` is high exactly when counters read (0,0).
  - `frame_count_out` increments on the edge into (0,0); wraps 63 → 0.
- Update path is a two-state FSM, EMPTY / PENDING; `upd_ready_out` = (state==EMPTY).
  - EMPTY, `upd_valid_in`=1: capture the update into the pending register, go to PENDING.
  - PENDING: ignore inputs; the held update is stable.
- Commit event is the edge on which the counters go from (H_TOTAL-1, V_ACTIVE-1) to (0, V_ACTIVE).
  - If PENDING on that edge: copy pending to `ballx_out`/`bally_out`/`angle_out`, pulse `commit_out` for the cycle showing (0,720), return to EMPTY.
  - If EMPTY on that edge: no change, no pulse.
- Simultaneous accept and commit edge: the update is accepted into PENDING but NOT committed. It is committed at the next frame's commit edge.
- Committed parameters are constant for all cycles where `active_draw_out`=1.
- Reset, on `rst_in` low, immediately and without a clock:
  - counters 0, syncs 0.
  - `active_draw_out` 1, `new_frame_out` 1 (counters at (0,0)).
  - `frame_count_out` 0, `commit_out` 0.
  - state EMPTY, so `upd_ready_out` 1.
  - `ballx_out`=INIT_X, `bally_out`=INIT_Y, `angle_out`=0.
  - Reset mid-operation discards any pending update.

## Timing
- First rising edge after `rst_in` deasserts moves the counters to (1,0).
- Sync and blank outputs have zero latency relative to the counters. The renderer pipeline delay is the renderer's responsibility.
- Handshake latency:
  - `upd_ready_out` falls the cycle after acceptance.
  - It rises the cycle after the commit edge.
- Worst-case accept-to-commit is one frame plus one cycle = 1,237,501 cycles.
- Frame period is 1,237,500 cycles.

## Test plan
- Reset/start: hold `rst_in` low 3 cycles, release.
  - Counters read (0,0) with `new_frame_out`=1.
  - Next edge gives (1,0).
  - `ballx_out`=16'h4000, `bally_out`=16'h0A00, `upd_ready_out`=1.
- Wrap: run to (1649,0) → (0,1); run to (1649,749) → (0,0).
  - On the (0,0) wrap, `frame_count_out` goes 0→1 and `new_frame_out` pulses one cycle.
  - Run 64 frames: the count wraps to 0.
- Sync windows, over one frame:
  - `hsync_out` high exactly 40 cycles per line, starting at hcount 1390.
  - `vsync_out` high only on lines 725..729.
  - `active_draw_out` high for 921,600 cycles.
- Commit: at (500,100) drive valid with ballx=16'h5000, bally=16'h2000, angle=1.
  - `upd_ready_out`=0 next cycle.
  - Outputs unchanged until counters read (0,720): new values appear there, `commit_out`=1 for that cycle only.
  - `upd_ready_out`=1 the following cycle.
- Collision: valid asserted with counters at (1649,719) and state EMPTY.
  - No commit at (0,720).
  - Values commit at the next frame's (0,720), 1,237,500 cycles later.
- Async reset mid-frame: with PENDING at (800,300), pull `rst_in` low between clock edges.
  - All outputs reach reset values before the next edge.
  - After release, no commit occurs at the following (0,720).
